mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one memory bus port between the core's instruction-fetch port (I) and load/store port (D).
//  Captures one request per port and issues them under a D-priority / anti-starvation policy.
//  Tracks outstanding reads in order and routes each read response back to the port that issued it.
//  Sits between the processor's imem/mem interfaces and a unified single-port memory controller.
// PARAMETERS
//  IADDR_W       16  I-port address width, zero-extended to 32 b on the bus
//  TAG_DEPTH     4   max outstanding bus reads (power of 2, >=2)
//  STARVE_LIMIT  4   cycles a pending I request may lose to D before I is forced to win
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous, active-high reset
//  i_addr       in   IADDR_W  fetch address; sampled when i_oe=1
//  i_oe         in   1        fetch request strobe
//  i_rdata      out  32       fetch data; valid when i_valid=1
//  i_valid      out  1        fetch data return, 1-cycle pulse
//  d_addr       in   32       load/store address
//  d_oe         in   4        byte read enables
//  d_we         in   4        byte write enables (|d_we marks a write)
//  d_wdata      in   32       store data
//  d_ready      out  1        D port can accept a request this cycle
//  d_rdata      out  32       load data; valid when d_valid=1
//  d_valid      out  1        load data return, 1-cycle pulse
//  bus_addr     out  32       bus address
//  bus_oe       out  4        bus byte read enables; a nonzero value is an issue strobe
//  bus_we       out  4        bus byte write enables
//  bus_wdata    out  32       bus store data
//  bus_ready    in   1        bus accepts an issue this cycle
//  bus_rdata    in   32       bus read data
//  bus_valid    in   1        bus read data valid; responses return in issue order
//  protocol_err out  1        sticky: bus_valid seen while no read was outstanding
// BEHAVIOUR
//  Reset: pending slots cleared, tag FIFO emptied, starve counter=0, protocol_err=0.
//   During rst: bus_oe=0, bus_we=0, i_valid=0, d_valid=0, d_ready=0.
//  Capture: one pending slot per port.
//   I slot loads when i_oe=1; if the slot is already full, the new address replaces the old one.
//   D slot loads {addr,oe,we,wdata} when (|d_oe | |d_we) and d_ready.
//   d_ready = !d_pend && (tag_count < TAG_DEPTH).
//  Issue: evaluated combinationally from the slots, so bus_* change one cycle after capture at earliest.
//   No same-cycle bypass.
//   A candidate is eligible when its slot is full, bus_ready=1, and (for reads) tag_count < TAG_DEPTH.
//   A pop does not free a tag entry in the same cycle.
//   Selection: D wins unless starve==STARVE_LIMIT and I is eligible; I wins when D is not eligible.
//   On issue the winner's slot clears and a read pushes its tag (0=I, 1=D); writes push no tag.
//   bus_oe/bus_we are 0 when nothing issues.
//   bus_addr/bus_wdata are don't-care in that case and are driven from the D slot.
//  I issue drives bus_addr = zero-extended i_addr, bus_oe=4'hf, bus_we=0.
//  Starve counter:
//   +1 (saturating at STARVE_LIMIT) each cycle the I slot is full and I does not issue.
//   Cleared when I issues or the I slot is empty.
//  Response: bus_valid with a nonempty FIFO pops the head tag.
//   The pop drives the tagged port's rdata=bus_rdata and valid=1 in the same cycle (combinational).
//   The other port's valid stays 0.
//   bus_valid with an empty FIFO is dropped and sets protocol_err.
//  Simultaneous push and pop: tag_count unchanged; the pointers wrap mod TAG_DEPTH.
//  Reset mid-operation: outstanding tags are discarded; any late responses set protocol_err.
//   The downstream controller is reset together with this block.
//  A capture and an issue of the same port in one cycle: the new request fills the slot the issue frees.
// STRUCTURE
//  CONSTS.v gets `ARB_TAG_I 1'b0 and `ARB_TAG_D 1'b1.
//  Sub-module arb_tag_fifo: 1-bit wide, TAG_DEPTH-entry synchronous FIFO.
//   Ports: push, pop, din, dout, count; count is needed for the full/empty checks.
//  Arbitration, slots and the starve counter live in the top.
// TESTING
//  - Lone fetch: i_oe with i_addr=16'h0100, bus_ready=1, 2-cycle memory.
//    -> bus_addr=32'h100, bus_oe=f one cycle later; i_valid + data returned; d_valid=0.
//  - Simultaneous requests: i_oe and load d_addr=32'h8000 in the same cycle.
//    -> D issues first, I the next cycle; responses are routed to the port that issued each.
//  - Starvation: hold a D load pending every cycle alongside a pending I request.
//    -> I issues within STARVE_LIMIT+1 cycles (=5).
//  - FIFO full: 4 reads outstanding with bus_valid withheld.
//    -> d_ready=0 and no new read issues; one bus_valid -> d_ready=1 on the next cycle.
//  - Store: d_we=4'h3, d_wdata=32'hdeadbeef.
//    -> bus_we=3 and bus_wdata as given; no tag pushed; a following response goes to the earlier reader.
//  - Reset with 2 reads outstanding, then 2 bus_valid pulses.
//    -> no i_valid/d_valid; protocol_err=1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// The tag values mark which port each outstanding bus read belongs to.
package mem_port_arbiter_pkg;

    localparam logic ARB_TAG_I = 1'b0;
    localparam logic ARB_TAG_D = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  oe;
        logic [3:0]  we;
        logic [31:0] wdata;
    } d_req_t;

    // Any write enable makes the request a store, even if read enables are also set.
    function automatic logic is_write(input d_req_t req);
        return |req.we;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, load/store port and unified memory bus grouped into one bundle.
// The master modport is the arbiter's view; slave is the core/controller side.
interface mem_port_arbiter_if #(
    parameter int IADDR_W = 16
);
    logic [IADDR_W-1:0] i_addr;
    logic               i_oe;
    logic [31:0]        i_rdata;
    logic               i_valid;

    logic [31:0]        d_addr;
    logic [3:0]         d_oe;
    logic [3:0]         d_we;
    logic [31:0]        d_wdata;
    logic               d_ready;
    logic [31:0]        d_rdata;
    logic               d_valid;

    logic [31:0]        bus_addr;
    logic [3:0]         bus_oe;
    logic [3:0]         bus_we;
    logic [31:0]        bus_wdata;
    logic               bus_ready;
    logic [31:0]        bus_rdata;
    logic               bus_valid;

    modport master (
        input  i_addr, i_oe, d_addr, d_oe, d_we, d_wdata,
        input  bus_ready, bus_rdata, bus_valid,
        output i_rdata, i_valid, d_ready, d_rdata, d_valid,
        output bus_addr, bus_oe, bus_we, bus_wdata
    );

    modport slave (
        output i_addr, i_oe, d_addr, d_oe, d_we, d_wdata,
        output bus_ready, bus_rdata, bus_valid,
        input  i_rdata, i_valid, d_ready, d_rdata, d_valid,
        input  bus_addr, bus_oe, bus_we, bus_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_tag_fifo.sv
// In-order record of which port owns each outstanding bus read (1-bit tags).
// The caller guarantees no push when full and no pop when empty.
module arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       din,
    output logic                       dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign dout = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the fetch (I) and load/store (D) ports with
// D priority, an I anti-starvation override, and in-order response routing.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int IADDR_W      = 16,
    parameter int TAG_DEPTH    = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.master    bus,
    output logic                  protocol_err
);
    localparam int CW = $clog2(TAG_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] TAG_DEPTH_C    = CW'(TAG_DEPTH);
    localparam logic [SW-1:0] STARVE_LIMIT_C = SW'(STARVE_LIMIT);

    logic               i_pend;
    logic [IADDR_W-1:0] i_addr_q;
    logic               d_pend;
    d_req_t             d_q;
    logic [SW-1:0]      starve;

    logic [CW-1:0]      tag_count;
    logic               tag_head;
    logic               tags_free;
    logic               d_ready_c;
    logic               d_cap;
    logic               i_elig;
    logic               d_elig;
    logic               issue_i;
    logic               issue_d;
    logic               push;
    logic               pop;

    // Issue decisions come only from registered slots, so nothing bypasses capture.
    always_comb begin
        tags_free = tag_count < TAG_DEPTH_C;
        d_ready_c = !rst && !d_pend && tags_free;
        d_cap     = d_ready_c && ((|bus.d_oe) || (|bus.d_we));
        d_elig    = !rst && d_pend && bus.bus_ready && (is_write(d_q) || tags_free);
        i_elig    = !rst && i_pend && bus.bus_ready && tags_free;
        issue_i   = i_elig && (!d_elig || starve == STARVE_LIMIT_C);
        issue_d   = d_elig && !issue_i;
        push      = issue_i || (issue_d && !is_write(d_q));
        pop       = !rst && bus.bus_valid && (tag_count != '0);
    end

    assign bus.d_ready   = d_ready_c;
    assign bus.bus_addr  = issue_i ? 32'(i_addr_q) : d_q.addr;
    assign bus.bus_oe    = issue_i ? 4'hf : (issue_d ? d_q.oe : 4'h0);
    assign bus.bus_we    = issue_d ? d_q.we : 4'h0;
    assign bus.bus_wdata = d_q.wdata;

    assign bus.i_rdata   = bus.bus_rdata;
    assign bus.d_rdata   = bus.bus_rdata;
    assign bus.i_valid   = pop && (tag_head == ARB_TAG_I);
    assign bus.d_valid   = pop && (tag_head == ARB_TAG_D);

    arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (issue_i ? ARB_TAG_I : ARB_TAG_D),
        .dout  (tag_head),
        .count (tag_count)
    );

    // A fresh I request overwrites the slot, including the one being issued now.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_pend       <= 1'b0;
            d_pend       <= 1'b0;
            starve       <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (bus.i_oe)    i_pend <= 1'b1;
            else if (issue_i) i_pend <= 1'b0;

            if (d_cap)        d_pend <= 1'b1;
            else if (issue_d) d_pend <= 1'b0;

            if (!i_pend || issue_i)          starve <= '0;
            else if (starve != STARVE_LIMIT_C) starve <= starve + SW'(1);

            if (bus.bus_valid && tag_count == '0) protocol_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.i_oe) i_addr_q <= bus.i_addr;
        if (d_cap)    d_q      <= '{addr: bus.d_addr, oe: bus.d_oe, we: bus.d_we, wdata: bus.d_wdata};
    end

endmodule
